// File: rtl/mips_pkg.sv
// Shared types for the MIPS load/store unit: access sizes, FSM states and the
// byte-lane element used for the big-endian memory port.
package mips_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    RESP  = 3'd3,
    ERR   = 3'd4,
    HALT  = 3'd5
  } lsu_state_t;

  // One memory byte lane; a port is declared as lane_t [NBYTES-1:0], lane 0 at the lowest address.
  typedef logic [7:0] lane_t;

  // Access width in bytes, clamped to the port width so illegal sizes never index past the lanes.
  function automatic int size_bytes(lsu_size_t size, int nbytes);
    int n;
    n = 1 << int'(size);
    return (n > nbytes) ? nbytes : n;
  endfunction

endpackage

// File: rtl/mips_lsu_align.sv
// Combinational lane logic: load extract/extend, sub-word store merge, and
// misalignment / illegal-size detection.
module mips_lsu_align
  import mips_pkg::*;
#(
  parameter  int XLEN   = 32,
  localparam int NBYTES = XLEN / 8,
  localparam int OFFW   = $clog2(NBYTES)
) (
  input  lsu_size_t              size,
  input  logic [OFFW-1:0]        offset,
  input  logic                   sign_ext,
  input  logic [XLEN-1:0]        wdata,
  input  lane_t [NBYTES-1:0]     rd_lanes,
  output logic                   err,
  output logic                   full,
  output logic [XLEN-1:0]        load_data,
  output lane_t [NBYTES-1:0]     merged
);

  int                  nb;
  int                  off;
  logic [XLEN-1:0]     field;
  logic [XLEN-1:0]     mask;
  lane_t [NBYTES-1:0]  wb;

  always_comb begin
    // NOTE: every signal gets a value before any branch so no latch is inferred.
    nb        = size_bytes(size, NBYTES);
    off       = int'(offset);
    err       = ((1 << int'(size)) > NBYTES) || ((off & (nb - 1)) != 0);
    full      = (nb == NBYTES);
    field     = '0;
    mask      = '1;
    wb        = wdata;
    merged    = rd_lanes;

    // Lane 'off' is the most significant byte of the field (big-endian).
    for (int i = 0; i < NBYTES; i++) begin
      if (i >= off && i < off + nb) begin
        field     = {field[XLEN-9:0], rd_lanes[i]};
        merged[i] = wb[OFFW'(off + nb - 1 - i)];
      end
      if (i < nb) begin
        mask = {mask[XLEN-9:0], 8'h00};
      end
    end

    load_data = (sign_ext && rd_lanes[offset][7]) ? (field | mask) : field;
  end

endmodule

// File: rtl/mips_lsu.sv
// Load/store unit: turns byte/half/word/double requests into word-aligned
// accesses on a whole-word-write memory, with read-modify-write and halt drain.
module mips_lsu
  import mips_pkg::*;
#(
  parameter  int XLEN           = 32,
  parameter  int MEM_RD_LATENCY = 1,
  localparam int NBYTES         = XLEN / 8,
  localparam int OFFW           = $clog2(NBYTES)
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [XLEN-1:0]     req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                rsp_valid,
  output logic                rsp_err,
  output logic [XLEN-1:0]     rsp_rdata,
  output logic [XLEN-1:0]     mem_addr,
  output lane_t [NBYTES-1:0]  mem_data_out,
  input  lane_t [NBYTES-1:0]  mem_data_in,
  output logic                mem_write_en,
  input  logic                halt_req,
  output logic                halted
);

  localparam int CNTW = 4;

  lsu_state_t          state_q, state_d;
  logic                accept;

  logic [XLEN-1:0]     addr_q;
  logic [OFFW-1:0]     off_q;
  lsu_size_t           size_q;
  logic                signed_q;
  logic                write_q;
  logic [XLEN-1:0]     wdata_q;
  lane_t [NBYTES-1:0]  rd_q;
  logic [CNTW-1:0]     cnt_q;

  lsu_size_t           a_size;
  logic [OFFW-1:0]     a_off;
  logic                a_err;
  logic                a_full;
  logic [XLEN-1:0]     a_load;
  lane_t [NBYTES-1:0]  a_merged;

  // In IDLE the aligner classifies the incoming request; afterwards it works on the latched one.
  assign a_size = (state_q == IDLE) ? lsu_size_t'(req_size) : size_q;
  assign a_off  = (state_q == IDLE) ? req_addr[OFFW-1:0]    : off_q;

  mips_lsu_align #(.XLEN(XLEN)) u_align (
    .size      (a_size),
    .offset    (a_off),
    .sign_ext  (signed_q),
    .wdata     (wdata_q),
    .rd_lanes  (rd_q),
    .err       (a_err),
    .full      (a_full),
    .load_data (a_load),
    .merged    (a_merged)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_b) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (halt_req) begin
          state_d = HALT;
        end else if (req_valid) begin
          accept = 1'b1;
          if (a_err)                  state_d = ERR;
          else if (req_write && a_full) state_d = WRITE;
          else                        state_d = READ;
        end
      end
      READ:  if (cnt_q == '0) state_d = write_q ? WRITE : RESP;
      WRITE: state_d = IDLE;
      RESP:  state_d = IDLE;
      ERR:   state_d = IDLE;
      HALT:  state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: the request latches are reset too, so the memory port reads all-zero after reset.
    if (rst_b) begin
      addr_q   <= '0;
      off_q    <= '0;
      size_q   <= SZ_B;
      signed_q <= 1'b0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
    end else if (accept) begin
      addr_q   <= {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
      off_q    <= req_addr[OFFW-1:0];
      size_q   <= lsu_size_t'(req_size);
      signed_q <= req_signed;
      write_q  <= req_write;
      wdata_q  <= req_wdata;
      rd_q     <= '0;
      cnt_q    <= CNTW'(MEM_RD_LATENCY - 1);
    end else if (state_q == READ) begin
      if (cnt_q == '0) rd_q  <= mem_data_in;
      else             cnt_q <= cnt_q - 1'b1;
    end
  end

  // Full-width stores replace every lane, so merging over the cleared rd_q yields req_wdata.
  assign req_ready    = (state_q == IDLE);
  assign halted       = (state_q == HALT);
  assign mem_addr     = addr_q;
  assign mem_write_en = (state_q == WRITE);
  assign mem_data_out = (state_q == WRITE) ? a_merged : '0;
  assign rsp_valid    = (state_q == WRITE) || (state_q == RESP) || (state_q == ERR);
  assign rsp_err      = (state_q == ERR);
  assign rsp_rdata    = (state_q == RESP) ? a_load : '0;

endmodule

// File: doc/mips_lsu.md
Name: mips_lsu

Overview:
Parametrised load/store unit sitting between the core data path and the byte-lane data memory port (mem_addr / mem_data_out / mem_data_in / mem_write_en).
- Converts single-request load/store transactions of byte/half/word/double size into word-aligned memory accesses.
- Performs sign/zero extension, and read-modify-write for sub-word stores, because memory has only a whole-word write enable.
- Supports a configurable memory read latency, XLEN of 32 or 64, and a drain-then-halt sequence that drives the core halted flag.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; NBYTES = XLEN/8 lanes, OFFW = log2(NBYTES).
MEM_RD_LATENCY, 1, cycles mem_data_in lags a stable mem_addr; legal values 1..8.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_b  in  1  reset, synchronous, active-high.
req_valid  in  1  request present.
req_ready  out  1  high only in IDLE and not halted; a request is accepted on an edge where req_valid && req_ready.
req_write  in  1  1 = store, 0 = load.
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double (legal only when XLEN = 64).
req_signed  in  1  loads only; 1 = sign-extend.
req_addr  in  XLEN  byte address.
req_wdata  in  XLEN  store data; the field occupies the low-order bytes.
rsp_valid  out  1  one-cycle completion pulse, one per accepted request.
rsp_err  out  1  qualified by rsp_valid; set for misaligned or illegal-size requests.
rsp_rdata  out  XLEN  qualified by rsp_valid on loads; 0 on stores and errors.
mem_addr  out  XLEN  word-aligned address: req_addr with the low OFFW bits cleared.
mem_data_out  out  8 x NBYTES  write lanes; lane i = byte at mem_addr+i (big-endian).
mem_data_in  in  8 x NBYTES  read lanes, same ordering as mem_data_out.
mem_write_en  out  1  whole-word write strobe.
halt_req  in  1  level request to stop after draining.
halted  out  1  sticky until reset.

Behaviour:
- Reset (rst_b = 1 at an edge): state enters IDLE.
  - rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
  - mem_addr = 0, every mem_data_out lane = 0, mem_write_en = 0, halted = 0.
  - Reset mid-access abandons the access; no write is issued, including a pending RMW write.
- States and transitions:
  - IDLE: accept request. Illegal size or addr[OFFW-1:0] not a multiple of 2^size goes to ERR. Otherwise a store with full-XLEN size goes to WRITE; loads and sub-word stores go to READ. mem_addr and the request fields are latched at acceptance.
  - READ: hold mem_addr for exactly MEM_RD_LATENCY cycles (down-counter). On the last cycle, sample mem_data_in. Loads go to RESP; sub-word stores go to WRITE with merged data.
  - WRITE: mem_write_en = 1 for exactly one cycle. mem_data_out carries req_wdata for a full store, or the merged word for a sub-word store. rsp_valid = 1 in the same cycle. Next state is IDLE.
  - RESP: rsp_valid = 1 with the extracted/extended rsp_rdata. Next state is IDLE.
  - ERR: rsp_valid = 1, rsp_err = 1, no memory activity (mem_write_en = 0). Next state is IDLE.
  - HALT: req_ready = 0, halted = 1. Terminal until reset.
- Halt handling:
  - halt_req is checked only in IDLE. If set, go to HALT and do not accept a simultaneous req_valid.
  - A halt_req arriving mid-access does not abort the access; it is honoured on return to IDLE.
- Latency with L = MEM_RD_LATENCY:
  - Full store: 1 cycle after acceptance.
  - Load: L+1 cycles.
  - Sub-word store: L+1 cycles, with the write in the final cycle.
  - Error: 1 cycle.
- Extract/merge rules, with o = addr offset and n = 2^size:
  - The field is lanes o..o+n-1, lane o being the MSB.
  - Loads zero- or sign-extend the field to XLEN. On XLEN = 64, a word load also extends.
  - Stores place req_wdata[8n-1:0] into those lanes; all other lanes keep the value that was read.
- No output is combinational from req_* except req_ready, which depends on state only.

Decomposition:
- Package mips_pkg:
  - lsu_size_t enum (SZ_B, SZ_H, SZ_W, SZ_D).
  - lsu_state_t enum (IDLE, READ, WRITE, RESP, ERR, HALT).
  - Byte-lane array typedef.
- Sub-module mips_lsu_align: purely combinational.
  - Extract + extend for loads.
  - Merge for stores.
  - Misalign/illegal-size detect.
  - Parametrised by XLEN.

Test Plan:
1. XLEN = 32, L = 1; SW addr 0x10, data 0xDEADBEEF -> mem_write_en high for one cycle, mem_addr 0x10, lanes DE,AD,BE,EF, rsp_valid in the same cycle, rsp_err = 0.
2. Word 0x12F45678 at 0x10; LB signed addr 0x11 -> rsp_rdata 0xFFFFFFF4 two cycles after acceptance; LBU -> 0x000000F4; LH signed addr 0x12 -> 0x00005678.
3. Word 0x11223344 at 0x10; SH 0x0000ABCD addr 0x12 -> one read cycle, then a single write of 0x1122ABCD with rsp_valid; no other write strobe.
4. LW addr 0x13 -> rsp_valid and rsp_err one cycle after acceptance, rsp_rdata 0, no mem_write_en; size 3 at XLEN = 32 -> same.
5. halt_req asserted during READ of an SB -> merged write completes, then halted = 1 and req_ready = 0 permanently. halt_req together with req_valid in IDLE -> request not accepted.
6. XLEN = 64, L = 3; SD then LW signed of a negative word -> correct lanes and a sign-extended 64-bit result after 4 cycles. rst_b asserted during READ of an SH -> no write, all outputs at reset values the next cycle.
